// File: rtl/acct_pkg.sv
// Shared types and constants for the ACCT configuration scheduler.
// Holds the FSM state encoding, per-group reglk bit tables and default widths.
package acct_pkg;

    localparam int unsigned IDX_W      = 8;
    localparam int unsigned DATA_W     = 32;
    localparam int unsigned LOCK_W     = 16;
    localparam int unsigned NUM_GROUPS = 4;
    localparam int unsigned GROUP_SIZE = 3;

    typedef enum logic [1:0] {
        INIT   = 2'd0,
        IDLE   = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_e;

    // reglk bit guarding each entry group (group = idx / GROUP_SIZE)
    localparam logic [3:0] WR_LOCK_BIT [NUM_GROUPS] = '{4'd5, 4'd13, 4'd1, 4'd7};
    localparam logic [3:0] RD_LOCK_BIT [NUM_GROUPS] = '{4'd4, 4'd2, 4'd0, 4'd6};

    // Lock bit for a group/direction, taken from the live reglk vector
    function automatic logic lock_hit(input logic [LOCK_W-1:0] reglk,
                                      input logic [1:0]        grp,
                                      input logic              we);
        return we ? reglk[WR_LOCK_BIT[grp]] : reglk[RD_LOCK_BIT[grp]];
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first asserted req scanning from ptr+1 (mod N).
// Ports: req (request vector), ptr (last granted index),
//        gnt (one-hot grant), gnt_idx (encoded grant index, 0 when none).
module rr_arbiter #(
    parameter  int unsigned N     = 3,
    localparam int unsigned PTR_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic [PTR_W-1:0] gnt_idx
);

    logic             found;
    logic [PTR_W-1:0] cand;

    // Rotating priority scan; the previously granted requester is checked last
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        cand    = '0;
        for (int unsigned i = 1; i <= N; i++) begin
            cand = PTR_W'((32'(ptr) + i) % N);
            if (!found && req[cand]) begin
                found     = 1'b1;
                gnt[cand] = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

endmodule

// File: rtl/acct_cfg_sched.sv
// ACCT register-file scheduler: boot-loads default policy into every entry, then
// arbitrates round-robin among requesters for the single-port ACCT interface,
// enforcing per-group reglk read/write locks, one response per accepted request.
// Ports: clk_i/rst_i (sync active-high); req_* requester side (ready is
// combinational one-hot); rsp_* one-hot response pulse with shared data/err;
// reglk_ctrl_i lock bits; default_policy_i boot values; init_done_o;
// mem_* ACCT index/data port with combinational mem_rdata_i.
module acct_cfg_sched #(
    parameter int unsigned NUM_REQ     = 3,
    parameter int unsigned NUM_ENTRIES = 3,
    parameter int unsigned IDX_W       = acct_pkg::IDX_W,
    parameter int unsigned DATA_W      = acct_pkg::DATA_W
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [NUM_REQ-1:0]            req_valid_i,
    input  logic [NUM_REQ-1:0]            req_we_i,
    input  logic [NUM_REQ*IDX_W-1:0]      req_idx_i,
    input  logic [NUM_REQ*DATA_W-1:0]     req_wdata_i,
    output logic [NUM_REQ-1:0]            req_ready_o,
    output logic [NUM_REQ-1:0]            rsp_valid_o,
    output logic [DATA_W-1:0]             rsp_rdata_o,
    output logic                          rsp_err_o,
    input  logic [15:0]                   reglk_ctrl_i,
    input  logic [NUM_ENTRIES*DATA_W-1:0] default_policy_i,
    output logic                          init_done_o,
    output logic                          mem_en_o,
    output logic                          mem_we_o,
    output logic [IDX_W-1:0]              mem_idx_o,
    output logic [DATA_W-1:0]             mem_wdata_o,
    input  logic [DATA_W-1:0]             mem_rdata_i
);

    import acct_pkg::*;

    localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned CNT_W = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   init_cnt_q, init_cnt_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [PTR_W-1:0]   gnt_q, gnt_d;
    logic               we_q, we_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [DATA_W-1:0]  wdata_q, wdata_d;
    logic [DATA_W-1:0]  rdata_q, rdata_d;
    logic               err_q, err_d;

    logic [DATA_W-1:0]  policy    [NUM_ENTRIES];
    logic [IDX_W-1:0]   req_idx   [NUM_REQ];
    logic [DATA_W-1:0]  req_wdata [NUM_REQ];

    logic [NUM_REQ-1:0] arb_gnt;
    logic [PTR_W-1:0]   arb_idx;

    logic [IDX_W-1:0]   grp;
    logic               in_range;
    logic               allowed;

    // Unpack flat buses into per-entry / per-requester views
    for (genvar e = 0; e < NUM_ENTRIES; e++) begin : g_policy
        assign policy[e] = default_policy_i[e*DATA_W +: DATA_W];
    end
    for (genvar r = 0; r < NUM_REQ; r++) begin : g_req
        assign req_idx[r]   = req_idx_i[r*IDX_W +: IDX_W];
        assign req_wdata[r] = req_wdata_i[r*DATA_W +: DATA_W];
    end

    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .req     (req_valid_i),
        .ptr     (ptr_q),
        .gnt     (arb_gnt),
        .gnt_idx (arb_idx)
    );

    // Access permission for the latched request, using reglk as seen in ACCESS
    assign grp      = idx_q / IDX_W'(GROUP_SIZE);
    assign in_range = (32'(idx_q) < NUM_ENTRIES) && (32'(grp) < NUM_GROUPS);
    assign allowed  = in_range && !lock_hit(reglk_ctrl_i, grp[1:0], we_q);

    // Next-state, datapath capture and decoded outputs
    always_comb begin
        state_d     = state_q;
        init_cnt_d  = init_cnt_q;
        ptr_d       = ptr_q;
        gnt_d       = gnt_q;
        we_d        = we_q;
        idx_d       = idx_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        err_d       = err_q;
        req_ready_o = '0;
        rsp_valid_o = '0;
        rsp_rdata_o = '0;
        rsp_err_o   = 1'b0;
        init_done_o = 1'b0;
        mem_en_o    = 1'b0;
        mem_we_o    = 1'b0;
        mem_idx_o   = '0;
        mem_wdata_o = '0;

        case (state_q)
            INIT: begin
                mem_en_o    = 1'b1;
                mem_we_o    = 1'b1;
                mem_idx_o   = IDX_W'(init_cnt_q);
                mem_wdata_o = policy[init_cnt_q];
                if (init_cnt_q == CNT_W'(NUM_ENTRIES - 1)) begin
                    init_cnt_d = '0;
                    state_d    = IDLE;
                end else begin
                    init_cnt_d = init_cnt_q + CNT_W'(1);
                end
            end
            IDLE: begin
                init_done_o = 1'b1;
                req_ready_o = arb_gnt;
                if (|arb_gnt) begin
                    gnt_d   = arb_idx;
                    ptr_d   = arb_idx;
                    we_d    = req_we_i[arb_idx];
                    idx_d   = req_idx[arb_idx];
                    wdata_d = req_wdata[arb_idx];
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                init_done_o = 1'b1;
                mem_en_o    = allowed;
                mem_we_o    = allowed && we_q;
                mem_idx_o   = allowed ? idx_q : '0;
                mem_wdata_o = (allowed && we_q) ? wdata_q : '0;
                err_d       = !allowed;
                rdata_d     = (allowed && !we_q) ? mem_rdata_i : '0;
                state_d     = RESP;
            end
            RESP: begin
                init_done_o        = 1'b1;
                rsp_valid_o[gnt_q] = 1'b1;
                rsp_rdata_o        = rdata_q;
                rsp_err_o          = err_q;
                rdata_d            = '0;
                err_d              = 1'b0;
                state_d            = IDLE;
            end
            default: state_d = INIT;
        endcase

        // Outputs are forced quiet for the whole reset cycle
        if (rst_i) begin
            req_ready_o = '0;
            rsp_valid_o = '0;
            rsp_rdata_o = '0;
            rsp_err_o   = 1'b0;
            init_done_o = 1'b0;
            mem_en_o    = 1'b0;
            mem_we_o    = 1'b0;
            mem_idx_o   = '0;
            mem_wdata_o = '0;
        end
    end

    // State and datapath registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= INIT;
            init_cnt_q <= '0;
            ptr_q      <= PTR_W'(NUM_REQ - 1);
            gnt_q      <= '0;
            we_q       <= 1'b0;
            idx_q      <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
            ptr_q      <= ptr_d;
            gnt_q      <= gnt_d;
            we_q       <= we_d;
            idx_q      <= idx_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            err_q      <= err_d;
        end
    end

endmodule

// File: tb/tb_acct_cfg_sched.sv
// Self-checking bench for acct_cfg_sched: directed boot/lock/round-robin/reset
// steps followed by randomized traffic, all checked against a transaction-level
// reference model. The bench also plays the ACCT register file.
module tb_acct_cfg_sched;

    localparam int unsigned NR = 3;
    localparam int unsigned NE = 12;
    localparam int unsigned IW = 8;
    localparam int unsigned DW = 32;
    localparam int unsigned PW = 2;

    logic              clk_i = 1'b0;
    logic              rst_i = 1'b1;
    logic [NR-1:0]     req_valid_i = '0;
    logic [NR-1:0]     req_we_i = '0;
    logic [NR*IW-1:0]  req_idx_i = '0;
    logic [NR*DW-1:0]  req_wdata_i = '0;
    logic [NR-1:0]     req_ready_o;
    logic [NR-1:0]     rsp_valid_o;
    logic [DW-1:0]     rsp_rdata_o;
    logic              rsp_err_o;
    logic [15:0]       reglk_ctrl_i = '0;
    logic [NE*DW-1:0]  default_policy_i = '0;
    logic              init_done_o;
    logic              mem_en_o;
    logic              mem_we_o;
    logic [IW-1:0]     mem_idx_o;
    logic [DW-1:0]     mem_wdata_o;
    logic [DW-1:0]     mem_rdata_i;

    always #5 clk_i = ~clk_i;

    acct_cfg_sched #(.NUM_REQ(NR), .NUM_ENTRIES(NE), .IDX_W(IW), .DATA_W(DW)) dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .req_valid_i      (req_valid_i),
        .req_we_i         (req_we_i),
        .req_idx_i        (req_idx_i),
        .req_wdata_i      (req_wdata_i),
        .req_ready_o      (req_ready_o),
        .rsp_valid_o      (rsp_valid_o),
        .rsp_rdata_o      (rsp_rdata_o),
        .rsp_err_o        (rsp_err_o),
        .reglk_ctrl_i     (reglk_ctrl_i),
        .default_policy_i (default_policy_i),
        .init_done_o      (init_done_o),
        .mem_en_o         (mem_en_o),
        .mem_we_o         (mem_we_o),
        .mem_idx_o        (mem_idx_o),
        .mem_wdata_o      (mem_wdata_o),
        .mem_rdata_i      (mem_rdata_i)
    );

    // ACCT register file stand-in
    logic [DW-1:0] stub_mem [256];
    assign mem_rdata_i = stub_mem[mem_idx_o];
    always @(posedge clk_i) begin
        if (mem_en_o && mem_we_o) stub_mem[mem_idx_o] <= mem_wdata_o;
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model state (transaction level)
    int            wr_bit [4] = '{5, 13, 1, 7};
    int            rd_bit [4] = '{4, 2, 0, 6};
    logic [DW-1:0] policy  [NE];
    logic [DW-1:0] ref_mem [NE];
    bit            m_boot = 1'b1;
    int            m_bpos = 0;
    int            m_busy = 0;
    int            m_last = NR - 1;
    int            m_cur = 0;
    bit            m_we = 1'b0;
    int            m_idx = 0;
    logic [DW-1:0] m_wd = '0;
    logic [DW-1:0] m_rd = '0;
    bit            m_err = 1'b0;
    logic [NR-1:0] hs_q = '0;
    int            grants [$];

    function automatic bit ref_ok(input int idx, input bit we, input logic [15:0] lk);
        int g;
        if (idx >= int'(NE)) return 1'b0;
        g = idx / 3;
        if (g > 3) return 1'b0;
        return we ? !lk[4'(wr_bit[g])] : !lk[4'(rd_bit[g])];
    endfunction

    // Per-cycle model evaluation and comparison, away from the active edge
    initial begin : monitor
        logic [NR-1:0] e_rdy, e_rv;
        logic          e_en, e_we, e_done, e_err, ok;
        logic [IW-1:0] e_idx;
        logic [DW-1:0] e_wd, e_rd;
        int            c;
        forever begin
            @(negedge clk_i);
            e_rdy = '0; e_rv = '0; e_en = 1'b0; e_we = 1'b0; e_done = 1'b0;
            e_err = 1'b0; e_idx = '0; e_wd = '0; e_rd = '0;
            hs_q = req_valid_i & req_ready_o;
            if (rst_i) begin
                m_boot = 1'b1; m_bpos = 0; m_busy = 0; m_last = NR - 1;
            end else if (m_boot) begin
                e_en = 1'b1; e_we = 1'b1; e_idx = IW'(m_bpos); e_wd = policy[m_bpos];
                ref_mem[m_bpos] = policy[m_bpos];
                m_bpos++;
                if (m_bpos == int'(NE)) m_boot = 1'b0;
            end else begin
                e_done = 1'b1;
                if (m_busy == 0) begin
                    for (int k = 1; k <= int'(NR); k++) begin
                        c = (m_last + k) % NR;
                        if (e_rdy == '0 && req_valid_i[PW'(c)]) begin
                            e_rdy[PW'(c)] = 1'b1;
                            m_cur = c; m_last = c; m_busy = 2;
                            m_we  = req_we_i[PW'(c)];
                            m_idx = int'(req_idx_i[c*IW +: IW]);
                            m_wd  = req_wdata_i[c*DW +: DW];
                            grants.push_back(c);
                        end
                    end
                end else if (m_busy == 2) begin
                    ok    = ref_ok(m_idx, m_we, reglk_ctrl_i);
                    e_en  = ok;
                    e_we  = ok && m_we;
                    e_idx = ok ? IW'(m_idx) : '0;
                    e_wd  = m_wd;
                    m_err = !ok;
                    m_rd  = (ok && !m_we) ? ref_mem[m_idx] : '0;
                    if (ok && m_we) ref_mem[m_idx] = m_wd;
                    m_busy = 1;
                end else begin
                    e_rv[PW'(m_cur)] = 1'b1;
                    e_rd  = m_rd;
                    e_err = m_err;
                    m_busy = 0;
                end
            end
            chk("req_ready", 32'(req_ready_o), 32'(e_rdy));
            chk("rsp_valid", 32'(rsp_valid_o), 32'(e_rv));
            chk("rsp_rdata", rsp_rdata_o, e_rd);
            chk("rsp_err", 32'(rsp_err_o), 32'(e_err));
            chk("init_done", 32'(init_done_o), 32'(e_done));
            chk("mem_en", 32'(mem_en_o), 32'(e_en));
            chk("mem_we", 32'(mem_we_o), 32'(e_we));
            if (e_en || rst_i) chk("mem_idx", 32'(mem_idx_o), 32'(e_idx));
            if (e_en && e_we) chk("mem_wdata", mem_wdata_o, e_wd);
            if (rst_i) chk("rst_wdata", mem_wdata_o, 32'h0);
        end
    end

    // Advance one cycle; requesters that handshook drop valid
    task automatic next_cyc();
        @(posedge clk_i);
        #1;
        req_valid_i = req_valid_i & ~hs_q;
    endtask

    // Issue one request and wait (bounded) for its response
    task automatic run_one(input int r, input bit we, input int idx, input logic [DW-1:0] wd,
                           input logic [15:0] lk, input logic [15:0] lk_after,
                           output logic [DW-1:0] rd, output logic err, output int lat);
        bit h;
        reglk_ctrl_i              = lk;
        req_we_i[PW'(r)]          = we;
        req_idx_i[r*IW +: IW]     = IW'(idx);
        req_wdata_i[r*DW +: DW]   = wd;
        req_valid_i[PW'(r)]       = 1'b1;
        lat = -1; rd = '0; err = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk_i);
            if (rsp_valid_o != '0) begin
                chk("rsp_who", 32'(rsp_valid_o), 32'(1) << r);
                rd = rsp_rdata_o; err = rsp_err_o; lat = n;
                next_cyc();
                break;
            end
            h = req_valid_i[PW'(r)] && req_ready_o[PW'(r)];
            next_cyc();
            if (h) reglk_ctrl_i = lk_after;
        end
        chk("rsp_latency", 32'(lat), 32'd2);
    endtask

    initial begin : stim
        logic [DW-1:0] rd;
        logic          err;
        int            lat;

        for (int i = 0; i < 256; i++) stub_mem[i] = '0;
        for (int e = 0; e < int'(NE); e++) begin
            policy[e] = DW'(e + 1);
            default_policy_i[e*DW +: DW] = policy[e];
        end

        // Boot load
        repeat (3) @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        for (int e = 0; e < int'(NE); e++) begin
            @(negedge clk_i);
            chk("boot_idx", 32'(mem_idx_o), 32'(e));
            chk("boot_data", mem_wdata_o, 32'(e + 1));
            chk("boot_ready", 32'(req_ready_o), 32'h0);
            @(posedge clk_i);
            #1;
        end
        @(negedge clk_i);
        chk("init_done_rise", 32'(init_done_o), 32'h1);
        @(posedge clk_i);
        #1;

        // Write then read back through different requesters
        run_one(0, 1'b1, 2, 32'hA5A5_0F0F, 16'h0, 16'h0, rd, err, lat);
        chk("wr_err", 32'(err), 32'h0);
        chk("wr_stored", stub_mem[2], 32'hA5A5_0F0F);
        run_one(1, 1'b0, 2, 32'h0, 16'h0, 16'h0, rd, err, lat);
        chk("rd_data", rd, 32'hA5A5_0F0F);
        chk("rd_err", 32'(err), 32'h0);

        // Locks and out-of-range
        run_one(0, 1'b1, 1, 32'hDEAD_BEEF, 16'h0020, 16'h0020, rd, err, lat);
        chk("wrlock_err", 32'(err), 32'h1);
        chk("wrlock_keep", stub_mem[1], 32'h2);
        run_one(1, 1'b0, 0, 32'h0, 16'h0010, 16'h0010, rd, err, lat);
        chk("rdlock_data", rd, 32'h0);
        chk("rdlock_err", 32'(err), 32'h1);
        run_one(1, 1'b1, 13, 32'h5555_AAAA, 16'h0, 16'h0, rd, err, lat);
        chk("oor_err", 32'(err), 32'h1);
        chk("oor_nowrite", stub_mem[13], 32'h0);
        run_one(0, 1'b1, 9, 32'h0BAD_F00D, 16'hFF7F, 16'hFF7F, rd, err, lat);
        chk("grp3_wr_err", 32'(err), 32'h0);
        chk("grp3_wr_data", stub_mem[9], 32'h0BAD_F00D);

        // Lock set after handshake but before access
        run_one(2, 1'b1, 3, 32'h1234_5678, 16'h0, 16'h2000, rd, err, lat);
        chk("race_err", 32'(err), 32'h1);
        chk("race_keep", stub_mem[3], 32'h4);
        reglk_ctrl_i = '0;

        // Round-robin with all requesters busy
        req_we_i = '0; req_idx_i = '0;
        grants.delete();
        req_valid_i = 3'b111;
        repeat (18) begin next_cyc(); req_valid_i = 3'b111; end
        req_valid_i = '0;
        chk("rr_count", 32'(grants.size()), 32'd6);
        for (int k = 0; k < 6; k++)
            if (k < grants.size()) chk("rr_order", 32'(grants[k]), 32'(k % 3));

        // Round-robin with requesters 0 and 2
        grants.delete();
        req_valid_i = 3'b101;
        repeat (12) begin next_cyc(); req_valid_i = 3'b101; end
        req_valid_i = '0;
        chk("rr02_count", 32'(grants.size()), 32'd4);
        for (int k = 0; k < 4; k++)
            if (k < grants.size()) chk("rr02_order", 32'(grants[k]), (k % 2 == 0) ? 32'd0 : 32'd2);

        // Reset during ACCESS of requester 2
        req_we_i[2] = 1'b1; req_idx_i[2*IW +: IW] = 8'd4; req_wdata_i[2*DW +: DW] = 32'hFFFF_0000;
        req_valid_i[2] = 1'b1;
        @(negedge clk_i);
        chk("rst_hs", 32'(req_ready_o), 32'h4);
        next_cyc();
        rst_i = 1'b1;
        @(negedge clk_i);
        chk("rst_mem_en", 32'(mem_en_o), 32'h0);
        chk("rst_rsp", 32'(rsp_valid_o), 32'h0);
        next_cyc();
        rst_i = 1'b0;
        @(negedge clk_i);
        chk("reinit_idx", 32'(mem_idx_o), 32'h0);
        chk("reinit_en", 32'(mem_en_o), 32'h1);
        chk("reinit_rsp", 32'(rsp_valid_o), 32'h0);
        repeat (NE) next_cyc();
        @(negedge clk_i);
        chk("reinit_done", 32'(init_done_o), 32'h1);
        chk("reinit_data", stub_mem[4], 32'h5);
        next_cyc();

        // Randomized traffic
        repeat (1500) begin
            for (int r = 0; r < int'(NR); r++) begin
                if (!req_valid_i[PW'(r)] && $urandom_range(0, 2) == 0) begin
                    req_we_i[PW'(r)]        = 1'($urandom_range(0, 1));
                    req_idx_i[r*IW +: IW]   = IW'($urandom_range(0, 15));
                    req_wdata_i[r*DW +: DW] = $urandom;
                    req_valid_i[PW'(r)]     = 1'b1;
                end
            end
            reglk_ctrl_i = 16'($urandom & $urandom & $urandom);
            next_cyc();
        end
        req_valid_i = '0;
        repeat (4) next_cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
